// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback request record used by
// the register file and its write arbiter.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic wb_req_t wb_pick(input logic sel1, input wb_req_t r0, input wb_req_t r1);
    return sel1 ? r1 : r0;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; prio names the requester that wins a conflict
// and flips to the loser after every grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU (0) and load unit (1).
// Define REGFILE_WB_SCOREBOARD_EN to build the per-register busy scoreboard.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_dest,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_dest,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] reg_write_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic              busy_1,
  output logic              busy_2
);

  logic [1:0] gnt;
  wb_req_t    req0;
  wb_req_t    req1;
  wb_req_t    sel_req;

  logic              we_q,   we_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({wb1_valid, wb0_valid}),
    .gnt (gnt)
  );

  // Ready is masked during reset so nothing can be accepted while rst is high.
  assign wb0_ready = gnt[0] & ~rst;
  assign wb1_ready = gnt[1] & ~rst;

  assign req0    = '{dest: wb0_dest, data: wb0_data};
  assign req1    = '{dest: wb1_dest, data: wb1_data};
  assign sel_req = wb_pick(gnt[1], req0, req1);

  always_comb begin
    we_d   = |gnt;
    dest_d = dest_q;
    data_d = data_q;
    if (|gnt) begin
      dest_d = sel_req.dest;
      data_d = sel_req.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      dest_q <= dest_d;
      data_q <= data_d;
    end
  end

  assign reg_write_en   = we_q;
  assign reg_write_dest = dest_q;
  assign reg_write_data = data_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] sb_q, sb_d;

  // Set is applied after clear: a same-cycle reissue means a newer producer is pending.
  always_comb begin
    sb_d = sb_q;
    if (we_q) begin
      sb_d[dest_q] = 1'b0;
    end
    if (issue_en) begin
      sb_d[issue_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign busy_1 = sb_q[rd_addr_1];
  assign busy_2 = sb_q[rd_addr_2];
`else
  logic unused_ok;
  assign unused_ok = ^{issue_en, issue_dest, rd_addr_1, rd_addr_2, 32'(NUM_REGS)};
  assign busy_1    = 1'b0;
  assign busy_2    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter: a request-level model predicts
// grants, busy bits and the write stream; a monitor checks the write port.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic        wb0_valid, wb1_valid;
  logic [4:0]  wb0_dest, wb1_dest;
  logic [15:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready;
  logic        reg_write_en;
  logic [4:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic        issue_en;
  logic [4:0]  issue_dest, rd_addr_1, rd_addr_2;
  logic        busy_1, busy_2;

  regfile_write_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .wb0_valid      (wb0_valid),
    .wb0_dest       (wb0_dest),
    .wb0_data       (wb0_data),
    .wb0_ready      (wb0_ready),
    .wb1_valid      (wb1_valid),
    .wb1_dest       (wb1_dest),
    .wb1_data       (wb1_data),
    .wb1_ready      (wb1_ready),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .issue_en       (issue_en),
    .issue_dest     (issue_dest),
    .rd_addr_1      (rd_addr_1),
    .rd_addr_2      (rd_addr_2),
    .busy_1         (busy_1),
    .busy_2         (busy_2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0]  dest;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  // Model state: pending requests, which requester wins the next conflict,
  // the write committing this cycle, and the set of registers awaiting a write.
  bit          pend0, pend1;
  logic [4:0]  pd0, pd1;
  logic [15:0] px0, px1;
  bit          g0p, g1p;
  bit          pref;
  bit          sb_m [32];
  bit          mw_v;
  logic [4:0]  mw_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pref = 1'b0;
    mw_v = 1'b0;
    g0p  = 1'b0;
    g1p  = 1'b0;
    for (int i = 0; i < 32; i++) sb_m[i] = 1'b0;
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      chk("rst_wb0_ready", 32'(wb0_ready), 32'd0);
      chk("rst_wb1_ready", 32'(wb1_ready), 32'd0);
      chk("rst_we", 32'(reg_write_en), 32'd0);
      chk("rst_dest", 32'(reg_write_dest), 32'd0);
      chk("rst_data", 32'(reg_write_data), 32'd0);
      chk("rst_busy_1", 32'(busy_1), 32'd0);
      chk("rst_busy_2", 32'(busy_2), 32'd0);
      if (i != ncyc - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drive_cycle(input bit w0 = 0, input logic [4:0] d0 = 0, input logic [15:0] x0 = 0,
                             input bit w1 = 0, input logic [4:0] d1 = 0, input logic [15:0] x1 = 0,
                             input bit ie = 0, input logic [4:0] idst = 0,
                             input logic [4:0] ra1 = 0, input logic [4:0] ra2 = 0);
    bit g0, g1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (g0p) pend0 = 1'b0;
    if (g1p) pend1 = 1'b0;
    if (!pend0 && w0) begin pend0 = 1'b1; pd0 = d0; px0 = x0; end
    if (!pend1 && w1) begin pend1 = 1'b1; pd1 = d1; px1 = x1; end
    wb0_valid  = pend0; wb0_dest = pd0; wb0_data = px0;
    wb1_valid  = pend1; wb1_dest = pd1; wb1_data = px1;
    issue_en   = ie;
    issue_dest = idst;
    rd_addr_1  = ra1;
    rd_addr_2  = ra2;
    if (pend0 && pend1) begin
      g0 = !pref;
      g1 = pref;
    end else begin
      g0 = pend0;
      g1 = pend1;
    end
    @(negedge clk);
    chk("wb0_ready", 32'(wb0_ready), 32'(g0));
    chk("wb1_ready", 32'(wb1_ready), 32'(g1));
    chk("busy_1", 32'(busy_1), 32'(sb_m[ra1]));
    chk("busy_2", 32'(busy_2), 32'(sb_m[ra2]));
    if (g0) begin
      exp_q.push_back('{pd0, px0, cyc + 1});
      pref = 1'b1;
    end else if (g1) begin
      exp_q.push_back('{pd1, px1, cyc + 1});
      pref = 1'b0;
    end
    if (mw_v) sb_m[mw_d] = 1'b0;
`ifdef REGFILE_WB_SCOREBOARD_EN
    if (ie) sb_m[idst] = 1'b1;
`endif
    mw_v = g0 | g1;
    mw_d = g0 ? pd0 : pd1;
    g0p  = g0;
    g1p  = g1;
  endtask

  // Write-port monitor: every cycle out of reset, reg_write_en must match
  // whether the oldest expected write is due now, with matching dest/data.
  initial begin
    exp_t e;
    bit   exp_we;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_we = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        chk("reg_write_en", 32'(reg_write_en), 32'(exp_we));
        if (exp_we) begin
          e = exp_q.pop_front();
          chk("reg_write_dest", 32'(reg_write_dest), 32'(e.dest));
          chk("reg_write_data", 32'(reg_write_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    wb0_valid = 1'b0; wb0_dest = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_dest = '0; wb1_data = '0;
    issue_en = 1'b0; issue_dest = '0; rd_addr_1 = '0; rd_addr_2 = '0;
    pend0 = 1'b0; pend1 = 1'b0;
    pd0 = '0; pd1 = '0; px0 = '0; px1 = '0; mw_d = '0;
    do_reset(2);

    // Contention: both continuously valid for four transfers.
    repeat (4) drive_cycle(1, 5'd1, 16'h1111, 1, 5'd2, 16'h2222);
    repeat (2) drive_cycle();

    // Single requester.
    drive_cycle(1, 5'd3, 16'h00A5);
    repeat (3) drive_cycle();

    // Hazard on r7 cleared by a load-unit write.
    drive_cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7);
    repeat (3) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd7);
    drive_cycle(0, 0, 0, 1, 5'd7, 16'hBEEF, 0, 0, 5'd7);
    repeat (3) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd7);

    // Set/clear collision on r4.
    drive_cycle(1, 5'd4, 16'h4444, 0, 0, 0, 0, 0, 0, 5'd4);
    drive_cycle(0, 0, 0, 0, 0, 0, 1, 5'd4, 0, 5'd4);
    repeat (3) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd4);

    repeat (400) begin
      drive_cycle($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), 16'($urandom),
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), 16'($urandom),
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // Reset mid-stream with both requesters valid, then conflict after release.
    repeat (2) drive_cycle(1, 5'd9, 16'h0909, 1, 5'd10, 16'h0A0A, 1, 5'd9, 5'd9, 5'd10);
    do_reset(2);
    repeat (4) drive_cycle(1, 5'd11, 16'h0B0B, 1, 5'd12, 16'h0C0C, 0, 0, 5'd9, 5'd10);

    repeat (100) begin
      drive_cycle($urandom_range(0, 1) != 0, 5'($urandom_range(0, 31)), 16'($urandom),
                  $urandom_range(0, 1) != 0, 5'($urandom_range(0, 31)), 16'($urandom),
                  $urandom_range(0, 1) == 0, 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    repeat (4) drive_cycle();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
